// File: rtl/irf_win_swap_seq.sv
// rtl/irf_win_swap_seq.sv - register-file window swap sequencer
// Queues window-swap requests and issues save/restore/done strobes one swap at a time.
module irf_win_swap_seq #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       swp_req_vld,
  output logic       swp_req_rdy,
  input  logic       swp_req_tid,
  input  logic [2:0] swp_req_old_cwp,
  input  logic [2:0] swp_req_new_cwp,
  output logic       save,
  output logic [3:0] save_addr,
  output logic       restore,
  output logic [3:0] restore_addr,
  output logic [1:0] swp_busy,
  output logic       swp_done,
  output logic       swp_done_tid
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t        state_q, state_d;
  logic [6:0]    mem [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;
  logic [6:0]    head;

  logic          w_tid;
  logic [2:0]    w_old, w_new;

  logic          save_d, restore_d, done_d, done_tid_d;
  logic [3:0]    save_addr_d, restore_addr_d;
  logic [1:0]    busy_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rdy looks only at registered occupancy, never at vld
  assign swp_req_rdy = (count != CW'(QDEPTH));
  assign push        = swp_req_vld & swp_req_rdy;
  assign head        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {swp_req_tid, swp_req_old_cwp, swp_req_new_cwp};
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Outputs are registered from the current state, so each strobe lags its state by one edge
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    save_d         = 1'b0;
    save_addr_d    = 4'h0;
    restore_d      = 1'b0;
    restore_addr_d = 4'h0;
    done_d         = 1'b0;
    done_tid_d     = 1'b0;
    busy_d         = 2'b00;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = (head[5:3] != head[2:0]) ? SAVE : DONE;
        end
      end
      SAVE: begin
        save_d      = 1'b1;
        save_addr_d = {w_tid, w_old};
        busy_d      = w_tid ? 2'b10 : 2'b01;
        state_d     = RESTORE;
      end
      RESTORE: begin
        restore_d      = 1'b1;
        restore_addr_d = {w_tid, w_new};
        busy_d         = w_tid ? 2'b10 : 2'b01;
        state_d        = DONE;
      end
      DONE: begin
        done_d     = 1'b1;
        done_tid_d = w_tid;
        busy_d     = w_tid ? 2'b10 : 2'b01;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      w_tid        <= 1'b0;
      w_old        <= 3'd0;
      w_new        <= 3'd0;
      save         <= 1'b0;
      save_addr    <= 4'h0;
      restore      <= 1'b0;
      restore_addr <= 4'h0;
      swp_done     <= 1'b0;
      swp_done_tid <= 1'b0;
      swp_busy     <= 2'b00;
    end else begin
      if (pop) begin
        w_tid <= head[6];
        w_old <= head[5:3];
        w_new <= head[2:0];
      end
      save         <= save_d;
      save_addr    <= save_addr_d;
      restore      <= restore_d;
      restore_addr <= restore_addr_d;
      swp_done     <= done_d;
      swp_done_tid <= done_tid_d;
      swp_busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_irf_win_swap_seq.sv
// tb/tb_irf_win_swap_seq.sv - scoreboard bench for irf_win_swap_seq
// Expected save/restore/done events are queued at acceptance and matched by a monitor.
module tb_irf_win_swap_seq;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic       swp_req_vld = 1'b0;
  logic       swp_req_rdy;
  logic       swp_req_tid = 1'b0;
  logic [2:0] swp_req_old_cwp = 3'd0;
  logic [2:0] swp_req_new_cwp = 3'd0;
  logic       save, restore, swp_done, swp_done_tid;
  logic [3:0] save_addr, restore_addr;
  logic [1:0] swp_busy;

  irf_win_swap_seq #(.QDEPTH(2)) dut (
    .clk(clk), .reset_l(reset_l),
    .swp_req_vld(swp_req_vld), .swp_req_rdy(swp_req_rdy),
    .swp_req_tid(swp_req_tid), .swp_req_old_cwp(swp_req_old_cwp),
    .swp_req_new_cwp(swp_req_new_cwp),
    .save(save), .save_addr(save_addr),
    .restore(restore), .restore_addr(restore_addr),
    .swp_busy(swp_busy), .swp_done(swp_done), .swp_done_tid(swp_done_tid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];
  int save_cyc_q[$];
  int done_cnt = 0;
  int acc_cnt = 0;
  int waits[32];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a swap is an ordered list of register-file events
  task automatic model_push(input logic tid, input logic [2:0] o, input logic [2:0] n);
    acc_cnt++;
    if (o != n) begin
      exp_q.push_back({2'd1, tid, o});
      exp_q.push_back({2'd2, tid, n});
    end
    exp_q.push_back({2'd3, 3'b000, tid});
  endtask

  task automatic ev(input int kind, input int addr);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", kind, 0);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, int'(e[5:4]));
      chk("event_addr", addr, int'(e[3:0]));
    end
  endtask

  always @(negedge clk) begin
    if (reset_l) begin
      chk("save_restore_overlap", int'(save & restore), 0);
      chk("save_addr_when_idle", int'(!save && save_addr != 4'h0), 0);
      chk("restore_addr_when_idle", int'(!restore && restore_addr != 4'h0), 0);
      if (save) begin
        save_cyc_q.push_back(cyc);
        ev(1, int'(save_addr));
      end
      if (restore) ev(2, int'(restore_addr));
      if (swp_done) begin
        done_cnt++;
        ev(3, int'(swp_done_tid));
        chk("busy_at_done", int'(swp_busy), swp_done_tid ? 2 : 1);
      end
    end
  end

  // Single request; returns the edge at which it was accepted, back at that edge's negedge
  task automatic send(input logic tid, input logic [2:0] o, input logic [2:0] n, output int acc);
    int g = 0;
    swp_req_vld = 1'b1; swp_req_tid = tid; swp_req_old_cwp = o; swp_req_new_cwp = n;
    while (!swp_req_rdy && g < 50) begin @(negedge clk); g++; end
    chk("send_rdy_timeout", int'(g >= 50), 0);
    acc = cyc + 1;
    model_push(tid, o, n);
    @(negedge clk);
    swp_req_vld = 1'b0;
  endtask

  task automatic gen(input int i, input bit rnd);
    swp_req_tid = i[0];
    if (rnd) begin
      swp_req_old_cwp = 3'($urandom);
      swp_req_new_cwp = ($urandom_range(0, 3) == 0) ? swp_req_old_cwp : 3'($urandom);
    end else begin
      swp_req_old_cwp = 3'(i);
      swp_req_new_cwp = 3'(i + 1);
    end
  endtask

  // vld held high; stops after max_n acceptances or max_c cycles
  task automatic stream_reqs(input int max_n, input int max_c, input bit rnd);
    int i = 0;
    int c = 0;
    for (int k = 0; k < 32; k++) waits[k] = 0;
    gen(0, rnd);
    swp_req_vld = 1'b1;
    while (i < max_n && c < max_c) begin
      if (swp_req_rdy) begin
        model_push(swp_req_tid, swp_req_old_cwp, swp_req_new_cwp);
        i++;
        @(negedge clk);
        gen(i, rnd);
      end else begin
        waits[i]++;
        @(negedge clk);
      end
      c++;
    end
    swp_req_vld = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || swp_busy != 2'b00) && g < 300) begin @(negedge clk); g++; end
    chk("drain_timeout", int'(g >= 300), 0);
    @(negedge clk);
  endtask

  // Cycle-accurate check of one isolated swap against the latency rules
  task automatic lat_check(input logic tid, input logic [2:0] o, input logic [2:0] n, input int acc);
    int k, sv, rs, dn;
    logic [1:0] bexp;
    bit sw;
    sw = (o != n);
    sv = acc + 2; rs = acc + 3; dn = sw ? acc + 4 : acc + 2;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      k = cyc;
      bexp = (k >= acc + 2 && k <= dn) ? (tid ? 2'b10 : 2'b01) : 2'b00;
      chk("lat_save", int'(save), int'(sw && k == sv));
      chk("lat_save_addr", int'(save_addr), (sw && k == sv) ? int'({tid, o}) : 0);
      chk("lat_restore", int'(restore), int'(sw && k == rs));
      chk("lat_restore_addr", int'(restore_addr), (sw && k == rs) ? int'({tid, n}) : 0);
      chk("lat_done", int'(swp_done), int'(k == dn));
      chk("lat_done_tid", int'(swp_done_tid), (k == dn) ? int'(tid) : 0);
      chk("lat_busy", int'(swp_busy), int'(bexp));
    end
  endtask

  initial begin
    int acc, g, d0;
    repeat (3) @(negedge clk);
    chk("rst_save", int'(save), 0);
    chk("rst_restore", int'(restore), 0);
    chk("rst_addrs", int'({save_addr, restore_addr}), 0);
    chk("rst_busy", int'(swp_busy), 0);
    chk("rst_done", int'({swp_done, swp_done_tid}), 0);
    reset_l = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", int'(swp_req_rdy), 1);

    // Swap tid1 3->5 accepted at edge 10
    while (cyc < 9) @(negedge clk);
    send(1'b1, 3'd3, 3'd5, acc);
    chk("accept_edge", acc, 10);
    lat_check(1'b1, 3'd3, 3'd5, acc);
    drain();

    // No-op swap tid0 2->2
    send(1'b0, 3'd2, 3'd2, acc);
    lat_check(1'b0, 3'd2, 3'd2, acc);
    drain();

    // Burst: FIFO fills, later request held off, saves every 4 cycles
    save_cyc_q.delete();
    stream_reqs(4, 100, 1'b0);
    chk("burst_2nd_no_wait", waits[1], 0);
    chk("burst_3rd_no_wait", waits[2], 0);
    chk("burst_held_off", int'(waits[3] > 0), 1);
    drain();
    chk("burst_save_count", save_cyc_q.size(), 4);
    for (int j = 1; j < save_cyc_q.size(); j++)
      chk("burst_save_spacing", save_cyc_q[j] - save_cyc_q[j-1], 4);

    // Reset during restore discards the active swap and the queued one
    d0 = done_cnt;
    stream_reqs(2, 20, 1'b0);
    g = 0;
    while (!restore && g < 30) begin @(negedge clk); g++; end
    chk("restore_seen", int'(restore), 1);
    reset_l = 1'b0;
    #1;
    chk("abort_restore", int'(restore), 0);
    chk("abort_save", int'(save), 0);
    chk("abort_busy", int'(swp_busy), 0);
    chk("abort_addrs", int'({save_addr, restore_addr}), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    #1;
    chk("rerst_rdy", int'(swp_req_rdy), 1);
    chk("rerst_busy", int'(swp_busy), 0);
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);

    // Random alternating-thread streams, vld held for 20 cycles
    for (int r = 0; r < 4; r++) begin
      d0 = done_cnt;
      acc_cnt = 0;
      stream_reqs(32, 20, 1'b1);
      drain();
      chk("stream_all_done", done_cnt - d0, acc_cnt);
      chk("stream_queue_empty", exp_q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
